// File: rtl/cpu_axi4lite_master_if.sv
// AXI4-Lite channel bundle between the CPU bridge and register slaves.
// master drives AW/W/AR payloads and B/R ready; slave answers.
interface cpu_axi4lite_master_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) ();
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );
endinterface

// File: rtl/cpu_axi4lite_master.sv
// Single-outstanding pulse-request to AXI4-Lite master bridge.
// Optional AXI4L_MASTER_STRB_EN: wstrb from request, else all ones.
module cpu_axi4lite_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    req,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    busy,
    output logic                    ack,
    output logic [DATA_WIDTH-1:0]   ack_rdata,
    output logic                    ack_err,
    cpu_axi4lite_master_if.master   axi
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t                state;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  aw_done;
    logic                  w_done;

    // A channel counts as finished once its valid is gone or its ready is up
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q || axi.wready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            ack_err   <= 1'b0;
            ack_rdata <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            ack     <= 1'b0;
            ack_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= req_addr;
                        busy   <= 1'b1;
                        if (req_we) begin
                            wdata_q   <= req_wdata;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        ack      <= 1'b1;
                        ack_err  <= axi.bresp[1];
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.rvalid) begin
                        rready_q  <= 1'b0;
                        ack       <= 1'b1;
                        ack_err   <= axi.rresp[1];
                        ack_rdata <= axi.rdata;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI4L_MASTER_STRB_EN
    logic [STRB_W-1:0] strb_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            strb_q <= '0;
        end else if (state == IDLE && req && req_we) begin
            strb_q <= req_wstrb;
        end
    end

    assign axi.wstrb = strb_q;
`else
    logic unused_strb;

    assign unused_strb = ^req_wstrb;
    assign axi.wstrb   = {STRB_W{1'b1}};
`endif

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    assign axi.rready  = rready_q;
endmodule

// File: tb/tb_cpu_axi4lite_master.sv
// Bench for cpu_axi4lite_master: vector table, corner sequences,
// random transactions against a transaction-level latency/result model.
module tb_cpu_axi4lite_master;
    logic        aclk;
    logic        areset_n;
    logic        req;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        busy;
    logic        ack;
    logic [31:0] ack_rdata;
    logic        ack_err;

    cpu_axi4lite_master_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

    cpu_axi4lite_master #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .busy      (busy),
        .ack       (ack),
        .ack_rdata (ack_rdata),
        .ack_err   (ack_err),
        .axi       (bus)
    );

    int total = 0;
    int bad = 0;
    int acks_total = 0;
    int exp_acks = 0;

    int aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cur_bresp, cur_rresp;
    logic [31:0] cur_rdata, cur_wdata;
    logic [2:0]  cur_addr;
    logic [3:0]  cur_strb;
    logic [31:0] last_rdata;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          ar_d;
        int          resp_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: raises each ready/valid after a programmable number of cycles
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b11;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'hFFFF_FFFF;
        bus.rresp   = 2'b11;
        forever begin
            tick();
            if (!areset_n) begin
                bus.awready = 1'b0;
                bus.wready  = 1'b0;
                bus.bvalid  = 1'b0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                ar_cnt = 0; r_cnt = 0;
                continue;
            end
            if (bus.awvalid) begin
                check("awaddr", 32'(bus.awaddr), 32'(cur_addr));
                check("awprot", 32'(bus.awprot), 32'd0);
            end
            if (bus.wvalid) begin
                check("wdata", bus.wdata, cur_wdata);
                check("wstrb", 32'(bus.wstrb), 32'(cur_strb));
            end
            if (bus.arvalid) begin
                check("araddr", 32'(bus.araddr), 32'(cur_addr));
                check("arprot", 32'(bus.arprot), 32'd0);
            end
            if (bus.awready) begin
                bus.awready = 1'b0; aw_cnt = 0;
            end else if (bus.awvalid) begin
                if (aw_cnt >= aw_dly) bus.awready = 1'b1;
                else aw_cnt++;
            end
            if (bus.wready) begin
                bus.wready = 1'b0; w_cnt = 0;
            end else if (bus.wvalid) begin
                if (w_cnt >= w_dly) bus.wready = 1'b1;
                else w_cnt++;
            end
            if (bus.arready) begin
                bus.arready = 1'b0; ar_cnt = 0;
            end else if (bus.arvalid) begin
                if (ar_cnt >= ar_dly) bus.arready = 1'b1;
                else ar_cnt++;
            end
            if (bus.bvalid) begin
                bus.bvalid = 1'b0; b_cnt = 0;
                bus.bresp = ~cur_bresp;
            end else if (bus.bready) begin
                if (b_cnt >= b_dly) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = cur_bresp;
                end else begin
                    b_cnt++;
                    bus.bresp = ~cur_bresp;
                end
            end
            if (bus.rvalid) begin
                bus.rvalid = 1'b0; r_cnt = 0;
                bus.rdata = ~cur_rdata;
                bus.rresp = ~cur_rresp;
            end else if (bus.rready) begin
                if (r_cnt >= r_dly) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = cur_rdata;
                    bus.rresp  = cur_rresp;
                end else begin
                    r_cnt++;
                    bus.rdata = ~cur_rdata;
                    bus.rresp = ~cur_rresp;
                end
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (ack) acks_total++;
        end
    end

    // Drive a request in the current cycle; returns one cycle later
    task automatic issue(input logic we, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req       = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        cur_addr  = a;
        cur_wdata = d;
`ifdef AXI4L_MASTER_STRB_EN
        cur_strb = s;
`else
        cur_strb = 4'hF;
`endif
        tick();
        req       = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 3'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic drop_req();
        req       = 1'b1;
        req_we    = 1'($urandom);
        req_addr  = ~cur_addr;
        req_wdata = ~cur_wdata;
        req_wstrb = 4'($urandom);
        tick();
        req = 1'b0;
    endtask

    task automatic wait_ack(input int start, output int lat);
        lat = start;
        exp_acks++;
        while (!ack && lat < 200) begin
            tick();
            lat++;
        end
        check("ack_seen", 32'(ack), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_awvalid"}, 32'(bus.awvalid), 32'd0);
        check({tag, "_wvalid"}, 32'(bus.wvalid), 32'd0);
        check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd0);
        check({tag, "_bready"}, 32'(bus.bready), 32'd0);
        check({tag, "_rready"}, 32'(bus.rready), 32'd0);
    endtask

    initial begin
        int lat;
        int exp_lat;
        int m;
        logic we;
        logic err;

        vecs[0] = '{1'b1, 3'd0, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 1,
                    2'b00, 32'h0, 1'b0, 32'h0, 4};
        vecs[1] = '{1'b1, 3'd4, 32'h01020304, 4'b1111, 3, 0, 0, 0,
                    2'b00, 32'h0, 1'b0, 32'h0, 6};
        vecs[2] = '{1'b1, 3'd2, 32'hAABBCCDD, 4'b1000, 0, 2, 0, 0,
                    2'b10, 32'h0, 1'b1, 32'h0, 5};
        vecs[3] = '{1'b0, 3'd4, 32'h0, 4'b0000, 0, 0, 0, 2,
                    2'b10, 32'h12345678, 1'b1, 32'h12345678, 5};
        vecs[4] = '{1'b0, 3'd7, 32'h0, 4'b0000, 0, 0, 1, 0,
                    2'b00, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 4};
        vecs[5] = '{1'b1, 3'd3, 32'h55AA55AA, 4'b0101, 2, 2, 0, 0,
                    2'b11, 32'h0, 1'b1, 32'hA5A5A5A5, 5};
        vecs[6] = '{1'b0, 3'd0, 32'h0, 4'b0000, 0, 0, 0, 0,
                    2'b01, 32'h0, 1'b0, 32'h0, 3};
        vecs[7] = '{1'b1, 3'd1, 32'h0BADF00D, 4'b0110, 1, 3, 0, 2,
                    2'b01, 32'h0, 1'b0, 32'h0, 8};

        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        cur_bresp = 2'b00; cur_rresp = 2'b00;
        cur_rdata = 32'h0; cur_wdata = 32'h0;
        cur_addr = 3'd0; cur_strb = 4'hF;
        last_rdata = 32'h0;
        req = 1'b0; req_we = 1'b0; req_addr = 3'd0;
        req_wdata = 32'h0; req_wstrb = 4'h0;
        areset_n = 1'b1;
        #2 areset_n = 1'b0;

        // Reset held while req pulses
        for (int i = 0; i < 4; i++) begin
            req    = ~req;
            req_we = 1'(i);
            tick();
            check_idle("rst");
            check("rst_rdata", ack_rdata, 32'h0);
            check("rst_err", 32'(ack_err), 32'd0);
        end
        req = 1'b0;
        areset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle");
        end

        // Vector table
        for (int i = 0; i < 8; i++) begin
            aw_dly = vecs[i].aw_d;
            w_dly  = vecs[i].w_d;
            ar_dly = vecs[i].ar_d;
            b_dly  = vecs[i].resp_d;
            r_dly  = vecs[i].resp_d;
            cur_bresp = vecs[i].resp;
            cur_rresp = vecs[i].resp;
            cur_rdata = vecs[i].rdata;
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            if (vecs[i].we) begin
                check($sformatf("v%0d_awv", i), 32'(bus.awvalid), 32'd1);
                check($sformatf("v%0d_wv", i), 32'(bus.wvalid), 32'd1);
            end else begin
                check($sformatf("v%0d_arv", i), 32'(bus.arvalid), 32'd1);
                last_rdata = vecs[i].rdata;
            end
            wait_ack(1, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_err", i), 32'(ack_err),
                  32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), ack_rdata, vecs[i].exp_rdata);
            tick();
            check($sformatf("v%0d_ack1", i), 32'(ack), 32'd0);
        end

        // AW stalled 3 cycles, W immediate
        aw_dly = 3; w_dly = 0; b_dly = 0;
        cur_bresp = 2'b00;
        issue(1'b1, 3'd5, 32'hCAFE0001, 4'b1100);
        check("aws_c1_aw", 32'(bus.awvalid), 32'd1);
        check("aws_c1_w", 32'(bus.wvalid), 32'd1);
        tick();
        check("aws_c2_aw", 32'(bus.awvalid), 32'd1);
        check("aws_c2_w", 32'(bus.wvalid), 32'd0);
        tick();
        tick();
        check("aws_c4_aw", 32'(bus.awvalid), 32'd1);
        check("aws_c4_b", 32'(bus.bready), 32'd0);
        tick();
        check("aws_c5_aw", 32'(bus.awvalid), 32'd0);
        check("aws_c5_b", 32'(bus.bready), 32'd1);
        wait_ack(5, lat);
        check("aws_lat", 32'(lat), 32'd6);
        check("aws_rdata", ack_rdata, last_rdata);
        tick();

        // Read with a dropped request while busy
        ar_dly = 0; r_dly = 2;
        cur_rresp = 2'b10; cur_rdata = 32'h12345678;
        issue(1'b0, 3'd4, 32'h0, 4'h0);
        drop_req();
        last_rdata = 32'h12345678;
        wait_ack(2, lat);
        check("drop_lat", 32'(lat), 32'd5);
        check("drop_rdata", ack_rdata, 32'h12345678);
        check("drop_err", 32'(ack_err), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drop_noack", 32'(ack), 32'd0);
            check("drop_nobusy", 32'(busy), 32'd0);
        end

        // Back-to-back: new read issued in the write ack cycle
        aw_dly = 0; w_dly = 0; b_dly = 0;
        cur_bresp = 2'b10;
        issue(1'b1, 3'd6, 32'h11112222, 4'b1111);
        wait_ack(1, lat);
        check("b2b_wlat", 32'(lat), 32'd3);
        check("b2b_werr", 32'(ack_err), 32'd1);
        ar_dly = 0; r_dly = 0;
        cur_rresp = 2'b00; cur_rdata = 32'h33334444;
        issue(1'b0, 3'd2, 32'h0, 4'h0);
        check("b2b_arv", 32'(bus.arvalid), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        last_rdata = 32'h33334444;
        wait_ack(1, lat);
        check("b2b_rlat", 32'(lat), 32'd3);
        check("b2b_rdata", ack_rdata, 32'h33334444);
        tick();

        // Async reset while waiting on B
        b_dly = 6;
        issue(1'b1, 3'd1, 32'h77778888, 4'b0001);
        lat = 0;
        while (!bus.bready && lat < 20) begin
            tick();
            lat++;
        end
        check("wr_bready", 32'(bus.bready), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        check_idle("arst");
        check("arst_rdata", ack_rdata, 32'h0);
        last_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("arst_hold");
        end
        areset_n = 1'b1;
        tick();
        ar_dly = 1; r_dly = 1;
        cur_rresp = 2'b00; cur_rdata = 32'hCAFEF00D;
        issue(1'b0, 3'd3, 32'h0, 4'h0);
        last_rdata = 32'hCAFEF00D;
        wait_ack(1, lat);
        check("post_rst_lat", 32'(lat), 32'd5);
        check("post_rst_rdata", ack_rdata, 32'hCAFEF00D);
        check("post_rst_err", 32'(ack_err), 32'd0);
        tick();

        // Random transactions against the latency/result model
        for (int n = 0; n < 40; n++) begin
            we     = 1'($urandom);
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            cur_bresp = 2'($urandom);
            cur_rresp = 2'($urandom);
            cur_rdata = $urandom;
            if (we) begin
                m = (aw_dly > w_dly) ? aw_dly : w_dly;
                exp_lat = 3 + m + b_dly;
                err = cur_bresp[1];
            end else begin
                exp_lat = 3 + ar_dly + r_dly;
                err = cur_rresp[1];
                last_rdata = cur_rdata;
            end
            issue(we, 3'($urandom), $urandom, 4'($urandom));
            lat = 1;
            if ($urandom_range(0, 2) == 0) begin
                drop_req();
                lat = 2;
            end
            wait_ack(lat, lat);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_err", n), 32'(ack_err), 32'(err));
            check($sformatf("rnd%0d_rdata", n), ack_rdata, last_rdata);
            if ($urandom_range(0, 1) == 1) tick();
        end

        for (int i = 0; i < 6; i++) tick();
        check("ack_count", 32'(acks_total), 32'(exp_acks));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
